ret_addr_stack_param: RTL

Parametrised return-address stack for the fetch/branch stage. It pushes `addr+INC` on `call` and pops on `ret`, driving a registered `target_out`. On a non-return cycle, `target_out` passes through `target_in`. Compared with the first-generation stack it adds:
- a selectable overflow policy (reject or circular overwrite)
- defined behaviour for simultaneous call/ret (tail call)
- a pipeline-advance enable and a flush
- occupancy and sticky error flags

---
 rtl/ret_addr_stack_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ret_addr_stack_param.sv
// Return-address stack: push addr+INC on call, pop on ret, registered target.
// Selectable full policy (reject or circular overwrite), tail-call pop-then-push, flush, sticky errors.
module ret_addr_stack_param #(
  parameter int unsigned D        = 12,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned OVF_MODE = 0,
  parameter int unsigned INC      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         call,
  input  logic                         ret,
  input  logic [D-1:0]                 addr,
  input  logic [D-1:0]                 target_in,
  output logic [D-1:0]                 target_out,
  output logic                         target_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [D-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_sp;
  logic [CW-1:0] r_count;
  logic [D-1:0]  r_tout;
  logic          r_tv;
  logic          r_ovf;
  logic          r_unf;

  logic [PW-1:0] w_sp_n, w_sp_inc, w_top_idx, w_widx;
  logic [CW-1:0] w_cnt_n;
  logic [D-1:0]  w_tout_n, w_push, w_wdata;
  logic          w_tv_n, w_ovf_n, w_unf_n, w_we, w_empty, w_full;

  // Pointer wrap by explicit compare so non-power-of-two depths work
  assign w_sp_inc  = (r_sp == PW'(DEPTH - 1)) ? '0 : r_sp + PW'(1);
  assign w_top_idx = (r_sp == '0) ? PW'(DEPTH - 1) : r_sp - PW'(1);
  assign w_push    = addr + D'(INC);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));

  always_comb begin
    w_sp_n   = r_sp;
    w_cnt_n  = r_count;
    w_tout_n = r_tout;
    w_tv_n   = r_tv;
    w_ovf_n  = r_ovf & ~clr_err;
    w_unf_n  = r_unf & ~clr_err;
    w_we     = 1'b0;
    w_widx   = r_sp;
    w_wdata  = w_push;
    if (flush) begin
      w_sp_n   = '0;
      w_cnt_n  = '0;
      w_tout_n = target_in;
      w_tv_n   = 1'b0;
    end else if (en) begin
      w_tout_n = target_in;
      w_tv_n   = 1'b0;
      if (call && ret) begin
        if (!w_empty) begin
          // Tail call: read the top before it is replaced with the new return address
          w_tout_n = r_mem[w_top_idx];
          w_tv_n   = 1'b1;
          w_we     = 1'b1;
          w_widx   = w_top_idx;
        end else begin
          w_unf_n = 1'b1;
          w_we    = 1'b1;
          w_sp_n  = w_sp_inc;
          w_cnt_n = CW'(1);
        end
      end else if (call) begin
        if (!w_full) begin
          w_we    = 1'b1;
          w_sp_n  = w_sp_inc;
          w_cnt_n = r_count + CW'(1);
        end else begin
          w_ovf_n = 1'b1;
          if (OVF_MODE == 1) begin
            w_we   = 1'b1;
            w_sp_n = w_sp_inc;
          end
        end
      end else if (ret) begin
        if (!w_empty) begin
          w_tout_n = r_mem[w_top_idx];
          w_tv_n   = 1'b1;
          w_sp_n   = w_top_idx;
          w_cnt_n  = r_count - CW'(1);
        end else begin
          w_unf_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp    <= '0;
      r_count <= '0;
      r_tout  <= '0;
      r_tv    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_sp    <= w_sp_n;
      r_count <= w_cnt_n;
      r_tout  <= w_tout_n;
      r_tv    <= w_tv_n;
      r_ovf   <= w_ovf_n;
      r_unf   <= w_unf_n;
    end
  end

  // Entry storage needs no reset; entries are only read after being written
  always_ff @(posedge clk) begin
    if (!reset && w_we) r_mem[w_widx] <= w_wdata;
  end

  assign target_out   = r_tout;
  assign target_valid = r_tv;
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule
